// File: rtl/vip_pkg.sv
// Shared types for the 3x3 window generator.
//   PIX_W       : pixel width (8 bits, the width of the line RAM).
//   pix_t       : one pixel.
//   row_state_e : how many completed lines of the current frame exist, which
//                 selects the top-border replication mode.
package vip_pkg;

  localparam int unsigned PIX_W = 8;

  typedef logic [PIX_W-1:0] pix_t;

  typedef enum logic [1:0] {
    Row0 = 2'd0,  // first line: no history in the line RAM
    Row1 = 2'd1,  // second line: only line r-1 is valid
    RowN = 2'd2   // third line onward: both RAM taps valid
  } row_state_e;

  // Saturating advance at the end of a line.
  function automatic row_state_e row_advance(input row_state_e cur);
    row_state_e nxt;
    case (cur)
      Row0:    nxt = Row1;
      default: nxt = RowN;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/line_shift_ram_8bit_3x3.sv
// Two-line shift RAM for a 3x3 neighbourhood.
// Every clken shifts one pixel in; the pixel at the same column of the
// previous line (taps0x) and of the line before that (taps1x) are registered
// out one cycle later together with post_clken.
//   clock      in  pixel clock
//   rst_n      in  asynchronous active-low reset (address and output regs only)
//   clken      in  shift enable, one per pixel
//   shiftin    in  newest pixel
//   post_clken out clken delayed by one cycle
//   taps0x     out line r-1 at the current column
//   taps1x     out line r-2 at the current column
module line_shift_ram_8bit_3x3
  import vip_pkg::*;
#(
  parameter int unsigned RAM_ADDR_MAX = 1936
) (
  input  logic clock,
  input  logic rst_n,
  input  logic clken,
  input  pix_t shiftin,
  output logic post_clken,
  output pix_t taps0x,
  output pix_t taps1x
);

  localparam int unsigned AddrW = (RAM_ADDR_MAX > 1) ? $clog2(RAM_ADDR_MAX) : 1;
  localparam logic [AddrW-1:0] AddrLast = AddrW'(RAM_ADDR_MAX - 1);

  // Contents are deliberately not reset; stale lines are hidden downstream
  // by top-border replication.
  pix_t line0_mem [RAM_ADDR_MAX];
  pix_t line1_mem [RAM_ADDR_MAX];

  logic [AddrW-1:0] addr_q, addr_d;
  logic             post_clken_q, post_clken_d;
  pix_t             taps0x_q, taps0x_d;
  pix_t             taps1x_q, taps1x_d;

  always_comb begin
    addr_d       = addr_q;
    taps0x_d     = taps0x_q;
    taps1x_d     = taps1x_q;
    post_clken_d = clken;
    if (clken) begin
      addr_d   = (addr_q == AddrLast) ? '0 : addr_q + AddrW'(1);
      taps0x_d = line0_mem[addr_q];
      taps1x_d = line1_mem[addr_q];
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      addr_q       <= '0;
      post_clken_q <= 1'b0;
      taps0x_q     <= '0;
      taps1x_q     <= '0;
    end else begin
      addr_q       <= addr_d;
      post_clken_q <= post_clken_d;
      taps0x_q     <= taps0x_d;
      taps1x_q     <= taps1x_d;
    end
  end

  // Line r-1 cascades into line r-2 at the same column.
  always_ff @(posedge clock) begin
    if (clken) begin
      line0_mem[addr_q] <= shiftin;
      line1_mem[addr_q] <= line0_mem[addr_q];
    end
  end

  assign post_clken = post_clken_q;
  assign taps0x     = taps0x_q;
  assign taps1x     = taps1x_q;

endmodule

// File: rtl/vip_matrix_generate_3x3_8bit.sv
// 3x3 pixel neighbourhood generator for an 8-bit raster stream.
// Feeds 3x3 filters (Sobel, median, erode/dilate). Two previous lines live in
// the line shift RAM; this module adds the window shift registers, row/column
// counters, top/left border replication and 2-cycle sync alignment.
//   clock, rst_n                 pixel clock, asynchronous active-low reset
//   per_frame_vsync/href/clken   input frame, line and pixel strobes
//   per_img_y                    input pixel
//   matrix_frame_vsync/href      input syncs delayed by 2 cycles
//   matrix_frame_clken           window-valid strobe (clken delayed by 2)
//   matrix_p11..p13              top row (line r-2), columns c-2..c
//   matrix_p21..p23              middle row (line r-1)
//   matrix_p31..p33              bottom row (current line r)
module vip_matrix_generate_3x3_8bit
  import vip_pkg::*;
#(
  parameter int unsigned IMG_HDISP = 1936,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned CNT_W     = 11
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              per_frame_vsync,
  input  logic              per_frame_href,
  input  logic              per_frame_clken,
  input  logic [DATA_W-1:0] per_img_y,
  output logic              matrix_frame_vsync,
  output logic              matrix_frame_href,
  output logic              matrix_frame_clken,
  output logic [DATA_W-1:0] matrix_p11,
  output logic [DATA_W-1:0] matrix_p12,
  output logic [DATA_W-1:0] matrix_p13,
  output logic [DATA_W-1:0] matrix_p21,
  output logic [DATA_W-1:0] matrix_p22,
  output logic [DATA_W-1:0] matrix_p23,
  output logic [DATA_W-1:0] matrix_p31,
  output logic [DATA_W-1:0] matrix_p32,
  output logic [DATA_W-1:0] matrix_p33
);

  pix_t taps0x;
  pix_t taps1x;
  logic post_clken;

  line_shift_ram_8bit_3x3 #(
    .RAM_ADDR_MAX(IMG_HDISP)
  ) u_line_ram (
    .clock     (clock),
    .rst_n     (rst_n),
    .clken     (per_frame_clken),
    .shiftin   (per_img_y),
    .post_clken(post_clken),
    .taps0x    (taps0x),
    .taps1x    (taps1x)
  );

  logic             vsync_d1_q, vsync_d2_q;
  logic             href_d1_q, href_d2_q;
  logic             clken_d2_q;
  pix_t             pix_d1_q, pix_d1_d;
  row_state_e       row_cnt_q, row_cnt_d;
  logic [CNT_W-1:0] col_cnt_q, col_cnt_d;
  // win[row][col]: row 0 = top (line r-2), col 0 = left (oldest column).
  pix_t [2:0][2:0]  win_q, win_d;
  pix_t [2:0]       row_new;
  logic             vsync_rise;
  logic             href_fall;

  // Current pixel registered to line up with the RAM taps.
  always_comb begin
    pix_d1_d = pix_d1_q;
    if (per_frame_clken) begin
      pix_d1_d = per_img_y;
    end
  end

  // Row counter: the frame-start clear wins over an end-of-line advance.
  always_comb begin
    vsync_rise = per_frame_vsync & ~vsync_d1_q;
    href_fall  = href_d1_q & ~per_frame_href;
    row_cnt_d  = row_cnt_q;
    if (vsync_rise) begin
      row_cnt_d = Row0;
    end else if (href_fall) begin
      row_cnt_d = row_advance(row_cnt_q);
    end
  end

  // Column counter is aligned with post_clken, hence keyed on the 1-cycle
  // delayed href; it saturates so an over-long line cannot wrap to the border.
  always_comb begin
    col_cnt_d = col_cnt_q;
    if (!href_d1_q) begin
      col_cnt_d = '0;
    end else if (post_clken && (col_cnt_q != '1)) begin
      col_cnt_d = col_cnt_q + CNT_W'(1);
    end
  end

  // Top-border replication: the RAM still holds the previous frame's lines
  // until this frame has written over them.
  always_comb begin
    row_new[0] = taps1x;
    row_new[1] = taps0x;
    row_new[2] = pix_d1_q;
    case (row_cnt_q)
      Row0: begin
        row_new[0] = pix_d1_q;
        row_new[1] = pix_d1_q;
      end
      Row1: begin
        row_new[0] = taps0x;
      end
      default: begin
      end
    endcase
  end

  // Window shift; the first column of a line fills all three columns so the
  // left border replicates.
  always_comb begin
    win_d = win_q;
    if (post_clken) begin
      for (int r = 0; r < 3; r++) begin
        if (col_cnt_q == '0) begin
          win_d[r] = {row_new[r], row_new[r], row_new[r]};
        end else begin
          win_d[r] = {row_new[r], win_q[r][2], win_q[r][1]};
        end
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d1_q <= 1'b0;
      vsync_d2_q <= 1'b0;
      href_d1_q  <= 1'b0;
      href_d2_q  <= 1'b0;
      clken_d2_q <= 1'b0;
      pix_d1_q   <= '0;
      row_cnt_q  <= Row0;
      col_cnt_q  <= '0;
      win_q      <= '0;
    end else begin
      vsync_d1_q <= per_frame_vsync;
      vsync_d2_q <= vsync_d1_q;
      href_d1_q  <= per_frame_href;
      href_d2_q  <= href_d1_q;
      clken_d2_q <= post_clken;
      pix_d1_q   <= pix_d1_d;
      row_cnt_q  <= row_cnt_d;
      col_cnt_q  <= col_cnt_d;
      win_q      <= win_d;
    end
  end

  assign matrix_frame_vsync = vsync_d2_q;
  assign matrix_frame_href  = href_d2_q;
  assign matrix_frame_clken = clken_d2_q;

  assign matrix_p11 = win_q[0][0];
  assign matrix_p12 = win_q[0][1];
  assign matrix_p13 = win_q[0][2];
  assign matrix_p21 = win_q[1][0];
  assign matrix_p22 = win_q[1][1];
  assign matrix_p23 = win_q[1][2];
  assign matrix_p31 = win_q[2][0];
  assign matrix_p32 = win_q[2][1];
  assign matrix_p33 = win_q[2][2];

endmodule

// File: tb/tb_vip_matrix_generate_3x3_8bit.sv
// Bench for vip_matrix_generate_3x3_8bit on an 8x4 image. Expected windows come
// from a clamped-neighbourhood model of each frame and are queued when a pixel
// is driven; a negedge monitor pops and compares whenever the window strobe
// is high.
module tb_vip_matrix_generate_3x3_8bit;

  localparam int unsigned HDisp = 8;
  localparam int unsigned VDisp = 4;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic       vs    = 1'b0;
  logic       hs    = 1'b0;
  logic       ck    = 1'b0;
  logic [7:0] y     = 8'h00;

  logic       m_vs, m_hs, m_ck;
  logic [7:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;

  always #5 clock = ~clock;

  vip_matrix_generate_3x3_8bit #(
    .IMG_HDISP(HDisp),
    .DATA_W   (8),
    .CNT_W    (4)
  ) dut (
    .clock             (clock),
    .rst_n             (rst_n),
    .per_frame_vsync   (vs),
    .per_frame_href    (hs),
    .per_frame_clken   (ck),
    .per_img_y         (y),
    .matrix_frame_vsync(m_vs),
    .matrix_frame_href (m_hs),
    .matrix_frame_clken(m_ck),
    .matrix_p11        (p11),
    .matrix_p12        (p12),
    .matrix_p13        (p13),
    .matrix_p21        (p21),
    .matrix_p22        (p22),
    .matrix_p23        (p23),
    .matrix_p31        (p31),
    .matrix_p32        (p32),
    .matrix_p33        (p33)
  );

  typedef struct packed {
    logic [71:0] win;
    int          stamp;
    int          fid;
    int          r;
    int          c;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  bit          chk_en = 1'b0;
  int          cnt55  = 0;
  logic [7:0]  frm [VDisp][HDisp];
  logic [71:0] cap [8][VDisp][HDisp];

  always @(posedge clock) cyc <= cyc + 1;

  // Window of pixel (r,c): rows r-2..r, cols c-2..c, indices clamped at 0.
  function automatic logic [71:0] model_win(input int r, input int c);
    logic [71:0] w;
    int rr;
    int cc;
    w = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        rr = (r - 2 + i < 0) ? 0 : r - 2 + i;
        cc = (c - 2 + j < 0) ? 0 : c - 2 + j;
        w  = {w[63:0], frm[rr][cc]};
      end
    end
    return w;
  endfunction

  task automatic chk72(input string nm, input logic [71:0] act, input logic [71:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_frame(input int fid, input int gapmode);
    exp_t e;
    int   g;
    vs = 1'b1;
    repeat (3) step();
    for (int r = 0; r < int'(VDisp); r++) begin
      hs = 1'b1;
      for (int c = 0; c < int'(HDisp); c++) begin
        g = (gapmode == 0) ? 0 : (gapmode == 1) ? 2 : int'($urandom_range(0, 3));
        repeat (g) step();
        ck      = 1'b1;
        y       = frm[r][c];
        e.win   = model_win(r, c);
        e.stamp = cyc;
        e.fid   = fid;
        e.r     = r;
        e.c     = c;
        exp_q.push_back(e);
        step();
        ck = 1'b0;
        y  = 8'($urandom);
      end
      hs = 1'b0;
      repeat (2 + int'($urandom_range(0, 2))) step();
    end
    vs = 1'b0;
    repeat (3) step();
  endtask

  // Monitor
  logic [71:0] mon_w;
  logic [71:0] prev_w = '0;
  logic [2:0]  hist1  = '0;
  logic [2:0]  hist2  = '0;
  exp_t        mon_e;

  always @(negedge clock) begin
    mon_w = {p11, p12, p13, p21, p22, p23, p31, p32, p33};
    if (!rst_n) begin
      checks++;
      if ({m_vs, m_hs, m_ck, mon_w} !== 75'd0) begin
        errors++;
        $display("FAIL reset_outputs: got %h, expected 0", {m_vs, m_hs, m_ck, mon_w});
      end
      hist1 = '0;
      hist2 = '0;
    end else begin
      if (chk_en) begin
        checks++;
        if ({m_vs, m_hs, m_ck} !== hist2) begin
          errors++;
          $display("FAIL sync_delay2: got %b, expected %b at cycle %0d",
                   {m_vs, m_hs, m_ck}, hist2, cyc);
        end
        if (m_ck) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_window: got strobe at cycle %0d, expected none", cyc);
          end else begin
            mon_e = exp_q.pop_front();
            if (mon_w !== mon_e.win) begin
              errors++;
              $display("FAIL window f%0d r%0d c%0d: got %h, expected %h",
                       mon_e.fid, mon_e.r, mon_e.c, mon_w, mon_e.win);
            end
            checks++;
            if (cyc - mon_e.stamp != 2) begin
              errors++;
              $display("FAIL latency f%0d r%0d c%0d: got %0d, expected 2",
                       mon_e.fid, mon_e.r, mon_e.c, cyc - mon_e.stamp);
            end
            cap[mon_e.fid][mon_e.r][mon_e.c] = mon_w;
            if (mon_e.fid == 4 && mon_e.r < 2) begin
              for (int k = 0; k < 9; k++) begin
                if (mon_w[k*8 +: 8] == 8'h55) cnt55++;
              end
            end
          end
        end else begin
          checks++;
          if (mon_w !== prev_w) begin
            errors++;
            $display("FAIL window_hold: got %h, expected %h at cycle %0d", mon_w, prev_w, cyc);
          end
        end
      end
      hist2 = hist1;
      hist1 = {vs, hs, ck};
    end
    prev_w = mon_w;
  end

  initial begin
    // Reset asserted with syncs and clken toggling.
    repeat (6) begin
      vs = 1'b1;
      hs = 1'($urandom);
      ck = hs & 1'($urandom);
      y  = 8'($urandom);
      step();
    end
    vs = 1'b0;
    hs = 1'b0;
    ck = 1'b0;
    step();
    rst_n  = 1'b1;
    chk_en = 1'b1;
    repeat (3) step();

    // Partial frame, then reset mid-line; nothing from it is expected.
    chk_en = 1'b0;
    vs     = 1'b1;
    repeat (2) step();
    for (int l = 0; l < 2; l++) begin
      hs = 1'b1;
      for (int c = 0; c < ((l == 0) ? int'(HDisp) : 5); c++) begin
        ck = 1'b1;
        y  = 8'($urandom);
        step();
        ck = 1'b0;
      end
      if (l == 0) begin
        hs = 1'b0;
        repeat (2) step();
      end
    end
    rst_n = 1'b0;
    repeat (5) begin
      ck = 1'($urandom);
      y  = 8'($urandom);
      step();
    end
    ck = 1'b0;
    hs = 1'b0;
    vs = 1'b0;
    step();
    rst_n  = 1'b1;
    chk_en = 1'b1;
    repeat (3) step();

    // Dense ramp frame.
    for (int r = 0; r < int'(VDisp); r++)
      for (int c = 0; c < int'(HDisp); c++) frm[r][c] = 8'(r * 16 + c);
    drive_frame(1, 0);
    chk72("ramp_r2c3", cap[1][2][3], 72'h01_02_03_11_12_13_21_22_23);
    chk72("ramp_r0c0", cap[1][0][0], 72'h00_00_00_00_00_00_00_00_00);
    chk72("ramp_r1c1", cap[1][1][1], 72'h00_00_01_00_00_01_10_10_11);

    // Same ramp with 1-of-3 clken duty must give identical windows.
    drive_frame(2, 1);
    for (int r = 0; r < int'(VDisp); r++)
      for (int c = 0; c < int'(HDisp); c++) chk72("gapped_vs_dense", cap[2][r][c], cap[1][r][c]);

    // Back-to-back constant frames: no stale 0x55 in the top rows of frame 2.
    for (int r = 0; r < int'(VDisp); r++)
      for (int c = 0; c < int'(HDisp); c++) frm[r][c] = 8'h55;
    drive_frame(3, 0);
    for (int r = 0; r < int'(VDisp); r++)
      for (int c = 0; c < int'(HDisp); c++) frm[r][c] = 8'hAA;
    drive_frame(4, 0);
    checks++;
    if (cnt55 != 0) begin
      errors++;
      $display("FAIL stale_0x55: got %0d bytes, expected 0", cnt55);
    end

    // Random pixels with random gaps.
    for (int f = 5; f < 7; f++) begin
      for (int r = 0; r < int'(VDisp); r++)
        for (int c = 0; c < int'(HDisp); c++) frm[r][c] = 8'($urandom);
      drive_frame(f, 2);
    end

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending windows, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
